// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding valid/addr_ok/data_ok slave over a word array,
// cleared after every reset. Optional misalignment reporting under `DMEM_ALIGN_CHECK_EN`.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  strb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        addr_err,
`endif
  output logic        busy
);

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LAT_LAST = 4'(LATENCY - 1);

  // Handshake: a request is accepted on the rising edge where req & addr_ok are both high;
  // the matching data_ok is a single-cycle pulse LATENCY cycles after that edge's cycle.
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic [3:0]              lat_cnt_q, lat_cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [3:0]              strb_q, strb_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    mis_q, mis_d;
  logic                    data_ok_q, data_ok_d;
  logic                    addr_err_q, addr_err_d;
  logic [31:0]             rdata_q, rdata_d;

  logic [31:0]             mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_idx;
  logic [31:0]             mem_wdata;

  logic                    commit;
  logic                    cur_wr, cur_mis;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic [3:0]              cur_strb;
  logic [31:0]             cur_wdata, cur_word;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    mis_d      = mis_q;
    data_ok_d  = 1'b0;
    addr_err_d = 1'b0;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    mem_idx    = init_cnt_q;
    mem_wdata  = '0;
    commit     = 1'b0;
    cur_wr     = wr_q;
    cur_idx    = idx_q;
    cur_strb   = strb_q;
    cur_wdata  = wdata_q;
    cur_mis    = mis_q;

    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req) begin
          cur_wr    = wr;
          cur_idx   = addr[ADDR_WIDTH+1:2];
          cur_strb  = strb;
          cur_wdata = wdata;
`ifdef DMEM_ALIGN_CHECK_EN
          cur_mis   = |addr[1:0];
`else
          cur_mis   = 1'b0;
`endif
          wr_d      = cur_wr;
          idx_d     = cur_idx;
          strb_d    = cur_strb;
          wdata_d   = cur_wdata;
          mis_d     = cur_mis;
          lat_cnt_d = 4'd1;
          // With a one-cycle latency the access completes on the accepting edge itself.
          if (LATENCY == 1) commit = 1'b1;
          else              state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q + 4'd1;
        if (lat_cnt_q == LAT_LAST) begin
          commit    = 1'b1;
          state_d   = ST_IDLE;
          lat_cnt_d = 4'd0;
        end
      end
      default: state_d = ST_INIT;
    endcase

    cur_word = mem_q[cur_idx];
    if (commit) begin
      data_ok_d  = 1'b1;
      addr_err_d = cur_mis;
      if (cur_wr) begin
        if (!cur_mis) begin
          mem_we  = 1'b1;
          mem_idx = cur_idx;
          for (int i = 0; i < 4; i++)
            mem_wdata[8*i +: 8] = cur_strb[i] ? cur_wdata[8*i +: 8] : cur_word[8*i +: 8];
        end
      end else begin
        rdata_d = cur_mis ? 32'h0 : cur_word;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      lat_cnt_q  <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      strb_q     <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      data_ok_q  <= 1'b0;
      addr_err_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      strb_q     <= strb_d;
      wdata_q    <= wdata_d;
      mis_q      <= mis_d;
      data_ok_q  <= data_ok_d;
      addr_err_q <= addr_err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array has no reset; INIT sweeps it to zero after every reset release.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end

  assign addr_ok = (state_q == ST_IDLE);
  assign busy    = ~addr_ok;
  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_err = addr_err_q;
`else
  logic unused_err;
  assign unused_err = addr_err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: behavioural word-array model plus expected-response queue.
module tb_dmem_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int WORDS = 1 << AW;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  strb = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok, data_ok, busy;
  logic [31:0] rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .addr(addr), .strb(strb),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .addr_err(addr_err),
`endif
    .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_mem [WORDS];
  logic [31:0] last_rd;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
    last_rd = 32'h0;
    exp_q.delete();
  endtask

  // Assert reset for two cycles, then count INIT length until addr_ok rises.
  task automatic do_reset();
    int n;
    resetn = 1'b0;
    req = 1'b0;
    #1;
    check("rst_data_ok", {31'b0, data_ok}, 32'h0);
    @(posedge clk); #1;
    check("rst_addr_ok", {31'b0, addr_ok}, 32'h0);
    check("rst_busy",    {31'b0, busy},    32'h1);
    check("rst_rdata",   rdata,            32'h0);
    check("rst_data_ok2", {31'b0, data_ok}, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    model_clear();
    n = 0;
    while (!addr_ok && n < 3000) begin
      if (data_ok) check("init_data_ok", 32'h1, 32'h0);
      @(posedge clk); #1;
      n++;
    end
    check("init_cycles", n, WORDS);
    check("idle_busy", {31'b0, busy}, 32'h0);
  endtask

  // Issue one request, wait for its response, check latency and read data.
  // Returns in the data_ok cycle so a following call is back-to-back.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit wait_resp = 1'b1);
    int          k;
    bit          got, mis;
    logic [AW-1:0] idx;
    req = 1'b1; wr = w; addr = a; strb = s; wdata = d;
    k = 0;
    while (!addr_ok && k < 50) begin @(posedge clk); #1; k++; end
    if (!addr_ok) begin
      check("accept_timeout", 32'h0, 32'h1);
      req = 1'b0;
      return;
    end
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    idx = a[AW+1:2];
    if (w) begin
      if (!mis)
        for (int i = 0; i < 4; i++)
          if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
    end else begin
      last_rd = mis ? 32'h0 : model_mem[idx];
    end
    if (wait_resp) exp_q.push_back(last_rd);
    @(posedge clk); #1;
    req = 1'b0;
    if (!wait_resp) return;
    got = 1'b0;
    for (int c = 1; c <= LAT + 4; c++) begin
      if (data_ok) begin
        check("latency", c, LAT);
        check(w ? "rdata_after_wr" : "rdata", rdata, exp_q.pop_front());
        check("busy_inv", {31'b0, busy}, {31'b0, ~addr_ok});
`ifdef DMEM_ALIGN_CHECK_EN
        check("addr_err", {31'b0, addr_err}, {31'b0, mis});
`endif
        got = 1'b1;
        break;
      end
      check("wait_addr_ok", {31'b0, addr_ok}, 32'h0);
      @(posedge clk); #1;
    end
    if (!got) begin
      check("data_ok_timeout", 32'h0, 32'h1);
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int acc, dok;
    logic [31:0] ra;
    do_reset();

    // top word of the window after INIT
    do_req(1'b0, 32'h0000_03FC, 4'h0, 32'h0);
    // full write then read, back-to-back
    do_req(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 4'b0000, 32'h0);
    check("plan_deadbeef", rdata, 32'hDEADBEEF);
    // single-byte strobe, then an all-zero strobe write
    do_req(1'b1, 32'h10, 4'b0010, 32'h0000AA00);
    do_req(1'b0, 32'h10, 4'b0000, 32'h0);
    check("plan_strb", rdata, 32'hDEADAAEF);
    do_req(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
    do_req(1'b0, 32'h10, 4'b0000, 32'h0);
    check("plan_strb0", rdata, 32'hDEADAAEF);
    // alias above the window
    do_req(1'b1, 32'h0000_1010, 4'b1111, 32'h12345678);
    do_req(1'b0, 32'h10, 4'b0000, 32'h0);
    check("plan_alias", rdata, 32'h12345678);

    // req held high for 3*LAT cycles from IDLE: accepts at 0, LAT, 2*LAT
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; addr = 32'h10; strb = 4'h0;
    acc = 0; dok = 0;
    for (int c = 0; c < 3 * LAT; c++) begin
      if (req && addr_ok) acc++;
      if (data_ok) dok++;
      @(posedge clk); #1;
    end
    req = 1'b0;
    last_rd = model_mem[4];
    check("held_req_accepts", acc, 3);
    check("held_req_data_oks", dok, 2);
    @(posedge clk); #1;

    // reset one cycle after accepting a write: write is lost, INIT reruns
    do_req(1'b1, 32'h20, 4'b1111, 32'hCAFEF00D, 1'b0);
    do_reset();
    do_req(1'b0, 32'h20, 4'b0000, 32'h0);
    check("plan_reset_lost", rdata, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
    do_req(1'b1, 32'h23, 4'b1111, 32'h11111111);
    do_req(1'b0, 32'h20, 4'b0000, 32'h0);
    check("plan_mis_wr", rdata, 32'h0);
    do_req(1'b0, 32'h21, 4'b0000, 32'h0);
`endif

    // randomized traffic over a small hot set of words with random upper bits
    for (int n = 0; n < 250; n++) begin
      ra = {$urandom_range(0, 255), 24'h0} | {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'b00};
`ifdef DMEM_ALIGN_CHECK_EN
      ra[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
`else
      ra[1:0] = 2'($urandom_range(0, 3));
`endif
      do_req(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clk); #1; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined MIPS core: the serving end of the data-side request that execute raises (address, 4-bit write strobe, store data).
- Accepts one request at a time over a valid/addr_ok/data_ok handshake.
- Performs a byte-strobed write or a word read on an internal word array.
- Answers after a fixed, parameterised latency.
- Clears its array after every reset before accepting traffic, so the core and bench see deterministic contents.

Parameters:
ADDR_WIDTH, 10, log2 of array depth in 32-bit words (1024 words = 4 KiB window)
LATENCY, 2, cycles from accept to data_ok; legal range 1..15

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
req  input  1  request valid; held with its payload until addr_ok seen
wr  input  1  1 = write, 0 = read
addr  input  32  byte address; word index = addr[ADDR_WIDTH+1:2], upper bits ignored
strb  input  4  byte write enables, bit i -> wdata[8i+7:8i]; ignored for reads
wdata  input  32  store data
addr_ok  output  1  request accepted this cycle when req & addr_ok
data_ok  output  1  one-cycle pulse: response complete
rdata  output  32  read data, valid only with data_ok
busy  output  1  high in INIT or WAIT; core uses it as a stall source

Behaviour:
- Reset (resetn low, async):
  - state=INIT, init counter=0, latency counter=0.
  - addr_ok=0, data_ok=0, rdata=0, busy=1.
  - Array contents are not reset by resetn; INIT clears them.
- INIT:
  - Writes 0 to word[init counter] each cycle and increments the counter.
  - After word 2^ADDR_WIDTH-1 is written, moves to IDLE.
  - Lasts exactly 2^ADDR_WIDTH cycles after resetn deasserts; addr_ok=0 throughout; req ignored.
- IDLE:
  - addr_ok=1, busy=0.
  - Accept at cycle T when req=1: latch wr, word index, strb, wdata; go to WAIT; latency counter=1.
  - With req=0: stay in IDLE.
- WAIT:
  - addr_ok=0, busy=1; req ignored, no queueing.
  - Counter increments each cycle.
  - At the clock edge ending cycle T+LATENCY-1:
    - Write: bytes with strb=1 are updated, strb=0 bytes kept; strb=0000 is a legal no-op write that still responds.
    - Read: the word is loaded into rdata.
  - State returns to IDLE at that same edge.
- Response:
  - data_ok=1 in cycle T+LATENCY only.
  - rdata holds its last value otherwise; a write response leaves rdata unchanged.
- Back-to-back:
  - addr_ok is 1 in the data_ok cycle, so the next request can be accepted at T+LATENCY.
  - Peak throughput is one request per LATENCY cycles.
  - A read accepted at T+LATENCY sees the write completed at T+LATENCY.
- Address wrap: addresses differing only above bit ADDR_WIDTH+1 alias the same word; addr[1:0] ignored (see optional feature).
- Reset mid-operation (WAIT or INIT):
  - Outstanding request dropped; no data_ok.
  - A write not yet committed is lost.
  - INIT restarts from word 0.
- Invariants: addr_ok and busy are always complements; data_ok never asserts in INIT.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined:
  - Adds output addr_err (1 bit, reset 0), asserted together with data_ok when the accepted request had addr[1:0]!=00.
  - A misaligned write does not modify the array.
  - A misaligned read returns rdata=0.
  - Response timing is unchanged.
- Not defined: the port is absent, addr[1:0] is ignored, and accesses behave as if aligned.

Test Plan:
- Reset release, ADDR_WIDTH=10 -> addr_ok=0 and busy=1 for exactly 1024 cycles, then addr_ok=1; read addr 0x0000_03FC -> data_ok 2 cycles after accept, rdata=0x0000_0000.
- Write addr 0x10, strb 1111, wdata 0xDEADBEEF at T, then read 0x10 at T+2 -> data_ok at T+2 (write) and T+4 (read), rdata=0xDEADBEEF.
- Write addr 0x10, strb 0010, wdata 0x0000AA00, then read 0x10 -> rdata=0xDEADAAEF; then strb 0000 write of 0xFFFFFFFF -> data_ok pulses, read still 0xDEADAAEF.
- Write 0x12345678 to addr 0x0000_1010, read addr 0x10 -> 0x12345678 (wrap alias); req held high during WAIT -> exactly one addr_ok per LATENCY cycles.
- resetn pulsed low one cycle after accepting a write of 0xCAFEF00D to 0x20 -> no data_ok, INIT reruns 1024 cycles, read 0x20 -> 0x00000000.
- DMEM_ALIGN_CHECK_EN: write 0x11111111 to 0x23 -> data_ok with addr_err=1; read 0x20 -> 0x00000000, addr_err=0; read 0x21 -> rdata=0, addr_err=1.
